// File: rtl/rgb_pkg.sv
// Shared types and defaults for the RGB matrix shift-register driver.
package rgb_pkg;

  localparam int RGB_FRAME_W  = 32;
  localparam int RGB_HALF_DIV = 210;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } rgb_shift_state_t;

endpackage

// File: rtl/rgb_half_tick.sv
// Half-period timebase for the display shift clock.
// Counts 0..HALF_DIV-1 while enabled and ticks on the last count.
module rgb_half_tick
  import rgb_pkg::*;
#(
  parameter int HALF_DIV = RGB_HALF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-run the divider while enabled; clear restarts a fresh transfer.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i)   cnt_q <= '0;
    else if (en_i)         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/rgb_shift_driver.sv
// Serial transmitter for the RGB display 74HC595-style chain.
// Takes one word per valid/ready handshake, shifts it MSB-first on DS with a
// self-generated SH_CP, then pulses ST_CP and reports done.
// Optional build macro: RGB_SHIFT_BLANK_EN (blank display via OE_n while busy).
module rgb_shift_driver
  import rgb_pkg::*;
#(
  parameter int WIDTH    = RGB_FRAME_W,
  parameter int HALF_DIV = RGB_HALF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] frame_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             DS,
  output logic             SH_CP,
  output logic             ST_CP,
  output logic             OE_n
);

  localparam int IW = $clog2(WIDTH);

  rgb_shift_state_t state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [IW-1:0]    idx_q;
  logic             shcp_q;
  logic             stcp_q;
  logic             done_q;
  logic             tick;
  logic             accept;

  assign ready_o = (state_q == IDLE);
  assign accept  = ready_o && valid_i;

  rgb_half_tick #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != IDLE),
    .clr_i  (accept),
    .tick_o (tick)
  );

`ifdef RGB_SHIFT_BLANK_EN
  logic oe_n_q;

  // Blank the display from accept until the latch phase finishes.
  always_ff @(posedge clk) begin
    if (!rst_n)                          oe_n_q <= 1'b0;
    else if (accept)                     oe_n_q <= 1'b1;
    else if (state_q == LATCH && tick)   oe_n_q <= 1'b0;
  end

  assign OE_n = oe_n_q;
`else
  assign OE_n = 1'b0;
`endif

  // Transfer FSM: DS is the shift-register MSB, so it only moves on accept
  // and on the SH_CP falling edge, giving a full half-period of setup/hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (valid_i) begin
          sreg_q  <= frame_i;
          idx_q   <= IW'(WIDTH - 1);
          state_q <= SHIFT_LO;
        end
        SHIFT_LO: if (tick) begin
          shcp_q  <= 1'b1;
          state_q <= SHIFT_HI;
        end
        SHIFT_HI: if (tick) begin
          shcp_q <= 1'b0;
          if (idx_q == '0) begin
            stcp_q  <= 1'b1;
            state_q <= LATCH;
          end else begin
            idx_q   <= idx_q - IW'(1);
            sreg_q  <= {sreg_q[WIDTH-2:0], 1'b0};
            state_q <= SHIFT_LO;
          end
        end
        LATCH: if (tick) begin
          stcp_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DS     = sreg_q[WIDTH-1];
  assign SH_CP  = shcp_q;
  assign ST_CP  = stcp_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_rgb_shift_driver.sv
// Directed bench for rgb_shift_driver at WIDTH=32, HALF_DIV=4.
module tb_rgb_shift_driver;

  localparam int W   = 32;
  localparam int H   = 4;
  localparam int LAT = (2*W + 1) * H;  // 260

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] frame;
  logic         valid;
  logic         ready, done, ds, shcp, stcp, oe_n;

  rgb_shift_driver #(.WIDTH(W), .HALF_DIV(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .frame_i (frame),
    .valid_i (valid),
    .ready_o (ready),
    .done_o  (done),
    .DS      (ds),
    .SH_CP   (shcp),
    .ST_CP   (stcp),
    .OE_n    (oe_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: sampled on the falling edge, rebuilds the word from SH_CP rises.
  int           sh_rises = 0, st_rises = 0, done_cnt = 0, oe_hi = 0;
  logic         sh_prev = 1'b0, st_prev = 1'b0;
  logic [W-1:0] rx = '0;
  always @(negedge clk) begin
    if (shcp && !sh_prev) begin
      rx       = {rx[W-2:0], ds};
      sh_rises = sh_rises + 1;
    end
    if (stcp && !st_prev) st_rises = st_rises + 1;
    if (done) done_cnt = done_cnt + 1;
    if (oe_n) oe_hi = oe_hi + 1;
    sh_prev = shcp;
    st_prev = stcp;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Call at a falling edge with ready high; returns the accept cycle stamp.
  task automatic send(input logic [W-1:0] w, output int acc);
    frame = w;
    valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    valid = 1'b0;
  endtask

  // Returns at the falling edge inside the done_o cycle.
  task automatic wait_done(input string tag, output int dc);
    dc = -1;
    for (int i = 0; i < LAT + 50; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int acc, acc2, dc, dc2, s0, t0, d0, o0;

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    frame = '0;

    // 1. reset state and quiet idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_outs", {done, ds, shcp, stcp, oe_n}, 0);
    @(negedge clk) rst_n = 1'b1;
    s0 = sh_rises;
    repeat (20) @(posedge clk);
    #1 chk("idle_no_shcp", sh_rises - s0, 0);

    // 2. single word
    @(negedge clk);
    s0 = sh_rises; t0 = st_rises; d0 = done_cnt; o0 = oe_hi;
    send(32'hA5C3_0F81, acc);
    chk("t2_busy", ready, 0);
    wait_done("t2", dc);
    chk("t2_latency", dc - acc, LAT);
    @(posedge clk);
    #1;
    chk("t2_word", rx, 32'hA5C3_0F81);
    chk("t2_shcp_rises", sh_rises - s0, 32);
    chk("t2_stcp_rises", st_rises - t0, 1);
    chk("t2_done_pulses", done_cnt - d0, 1);
`ifdef RGB_SHIFT_BLANK_EN
    chk("t2_oe_blank", oe_hi - o0, LAT);
`else
    chk("t2_oe_low", oe_hi - o0, 0);
`endif

    // 3. boundary words back-to-back, second accepted at the end of the done cycle
    @(negedge clk);
    s0 = sh_rises; t0 = st_rises;
    send(32'h0000_0000, acc);
    wait_done("t3a", dc);
    send(32'hFFFF_FFFF, acc2);
    chk("t3_b2b_accept", acc2 - dc, 1);
    chk("t3_word0", rx, 32'h0000_0000);
    wait_done("t3b", dc2);
    chk("t3_latency2", dc2 - acc2, LAT);
    // done-to-done spacing: one done cycle plus a full transfer
    chk("t3_done_gap", dc2 - dc, LAT + 1);
    @(posedge clk);
    #1;
    chk("t3_word1", rx, 32'hFFFF_FFFF);
    chk("t3_shcp_rises", sh_rises - s0, 64);
    chk("t3_stcp_rises", st_rises - t0, 2);

    // 4. valid/frame activity while busy is ignored
    @(negedge clk);
    send(32'h1234_5678, acc);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      valid = 1'b1;
      frame = 32'hDEAD_0000 | i;
      repeat (5) @(negedge clk);
    end
    valid = 1'b0;
    wait_done("t4", dc);
    chk("t4_latency", dc - acc, LAT);
    @(posedge clk);
    #1 chk("t4_word", rx, 32'h1234_5678);

    // 5. reset mid-transfer after 10 bits
    @(negedge clk);
    s0 = sh_rises; t0 = st_rises; d0 = done_cnt;
    send(32'hC0FF_EE11, acc);
    for (int i = 0; i < LAT && (sh_rises - s0) < 10; i++) begin
      @(posedge clk);
      #1;
    end
    chk("t5_reach_bit10", sh_rises - s0, 10);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst_ready", ready, 1);
    chk("t5_rst_outs", {done, ds, shcp, stcp, oe_n}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (LAT + 40) @(posedge clk);
    #1;
    chk("t5_no_stcp", st_rises - t0, 0);
    chk("t5_no_done", done_cnt - d0, 0);
    @(negedge clk);
    send(32'h5A5A_F00F, acc);
    wait_done("t5", dc);
    chk("t5_latency", dc - acc, LAT);
    @(posedge clk);
    #1 chk("t5_word", rx, 32'h5A5A_F00F);

`ifndef RGB_SHIFT_BLANK_EN
    chk("oe_never_high", oe_hi, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
